// File: rtl/tank_shell_if.sv
`default_nettype none
// ============================================================================
// Module   : tank_shell_if
// Desc     : Bundle between tank controller, terrain lookup and shell engine.
//            Optional macro TANK_SHELL_WIND_EN adds the signed wind input.
// Revision : 1.0 - initial release
// ============================================================================
interface tank_shell_if;
    logic       shoot;
    logic [9:0] TankX;
    logic [9:0] TankY;
    logic [1:0] Direction;
    logic [9:0] y_component;
    logic [9:0] TargetX;
    logic [9:0] TargetY;
    logic [9:0] terrain_x;
    logic [9:0] terrain_y;
    logic [9:0] ShellX;
    logic [9:0] ShellY;
    logic       shell_active;
    logic       explode_active;
    logic [3:0] ExplodeR;
    logic       hit;
    logic       miss;
    logic       busy;
`ifdef TANK_SHELL_WIND_EN
    logic signed [2:0] wind;
`endif

    modport master (
        output shoot, TankX, TankY, Direction, y_component, TargetX, TargetY, terrain_y,
        input  terrain_x, ShellX, ShellY, shell_active, explode_active, ExplodeR,
               hit, miss, busy
`ifdef TANK_SHELL_WIND_EN
        , output wind
`endif
    );

    modport slave (
        input  shoot, TankX, TankY, Direction, y_component, TargetX, TargetY, terrain_y,
        output terrain_x, ShellX, ShellY, shell_active, explode_active, ExplodeR,
               hit, miss, busy
`ifdef TANK_SHELL_WIND_EN
        , input wind
`endif
    );
endinterface
`default_nettype wire

// File: rtl/tank_shell.sv
`default_nettype none
// ============================================================================
// Module   : tank_shell
// Desc     : Per-frame ballistic shell engine: flight, hit/terrain/exit
//            detection and explosion phase. Macro TANK_SHELL_WIND_EN adds wind.
// Revision : 1.0 - initial release
// ============================================================================
module tank_shell #(
    parameter int VX_SPEED       = 2,
    parameter int AIM_SHIFT      = 1,
    parameter int VY_MAX         = 15,
    parameter int GRAV_DIV       = 4,
    parameter int LAUNCH_OFS     = 6,
    parameter int HIT_R          = 4,
    parameter int EXPLODE_R_MAX  = 8,
    parameter int EXPLODE_FRAMES = 16
) (
    input  wire logic   frame_clk,
    input  wire logic   Reset_n,
    tank_shell_if.slave shell_if
);

    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam int EW = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

    localparam logic [GW-1:0]      C_GRAV_LAST = GW'(GRAV_DIV - 1);
    localparam logic [EW-1:0]      C_EXP_LAST  = EW'(EXPLODE_FRAMES - 1);
    localparam logic signed [11:0] C_VMAX      = 12'(VY_MAX);
    localparam logic signed [11:0] C_HIT_R     = 12'(HIT_R);
    localparam logic signed [11:0] C_XMAX      = 12'sd639;
    localparam logic signed [11:0] C_YMAX      = 12'sd479;
    localparam logic [3:0]         C_RMAX      = 4'(EXPLODE_R_MAX);
    localparam logic [10:0]        C_LAUNCH    = 11'(LAUNCH_OFS);
    localparam logic signed [5:0]  C_VX        = 6'(VX_SPEED);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLIGHT  = 2'd1,
        S_EXPLODE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic signed [10:0] x_q, x_d, y_q, y_d;
    logic signed [5:0]  vx_q, vx_d, vy_q, vy_d;
    logic [GW-1:0]      grav_q, grav_d;
    logic [EW-1:0]      exp_q, exp_d;
    logic [3:0]         rad_q, rad_d;
    logic               hit_q, hit_d, miss_q, miss_d;
`ifdef TANK_SHELL_WIND_EN
    logic [2:0]         wcnt_q, wcnt_d;
`endif

    function automatic logic signed [5:0] sat_v(input logic signed [11:0] v);
        logic signed [5:0] r;
        if (v > C_VMAX)       r = C_VMAX[5:0];
        else if (v < -C_VMAX) r = 6'(-C_VMAX);
        else                  r = v[5:0];
        return r;
    endfunction

    logic signed [11:0] w_nx, w_ny, w_dx, w_dy, w_ter, w_vy0;
    logic signed [9:0]  w_aim;
    logic [10:0]        w_y0;
    logic               w_hit, w_ground, w_off;

    // Next position always uses the velocity held before this edge's update.
    assign w_nx  = {x_q[10], x_q} + {{6{vx_q[5]}}, vx_q};
    assign w_ny  = {y_q[10], y_q} + {{6{vy_q[5]}}, vy_q};
    assign w_dx  = w_nx - {2'b00, shell_if.TargetX};
    assign w_dy  = w_ny - {2'b00, shell_if.TargetY};
    assign w_ter = {2'b00, shell_if.terrain_y};

    assign w_aim = $signed(shell_if.y_component) >>> AIM_SHIFT;
    assign w_vy0 = -{{2{w_aim[9]}}, w_aim};
    assign w_y0  = {1'b0, shell_if.TankY} - C_LAUNCH;

    assign w_hit    = (w_dx >= -C_HIT_R) && (w_dx <= C_HIT_R) &&
                      (w_dy >= -C_HIT_R) && (w_dy <= C_HIT_R);
    assign w_ground = !w_ny[11] && (w_ny >= w_ter);
    assign w_off    = w_nx[11] || (w_nx > C_XMAX) || (w_ny > C_YMAX);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            grav_q  <= '0;
            exp_q   <= '0;
            rad_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
`ifdef TANK_SHELL_WIND_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            grav_q  <= grav_d;
            exp_q   <= exp_d;
            rad_q   <= rad_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
`ifdef TANK_SHELL_WIND_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        grav_d  = grav_q;
        exp_d   = exp_q;
        rad_d   = rad_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
`ifdef TANK_SHELL_WIND_EN
        wcnt_d  = wcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (shell_if.shoot) begin
                    state_d = S_FLIGHT;
                    x_d     = {1'b0, shell_if.TankX};
                    y_d     = w_y0;
                    vx_d    = (shell_if.Direction == 2'd0) ? -C_VX : C_VX;
                    vy_d    = sat_v(w_vy0);
                    grav_d  = '0;
`ifdef TANK_SHELL_WIND_EN
                    wcnt_d  = '0;
`endif
                end
            end
            S_FLIGHT: begin
                if (grav_q == C_GRAV_LAST) begin
                    grav_d = '0;
                    vy_d   = sat_v({{6{vy_q[5]}}, vy_q} + 12'sd1);
                end else begin
                    grav_d = grav_q + 1'b1;
                end
`ifdef TANK_SHELL_WIND_EN
                wcnt_d = wcnt_q + 3'd1;
                if (wcnt_q == 3'd7)
                    vx_d = sat_v({{6{vx_q[5]}}, vx_q} + {{9{shell_if.wind[2]}}, shell_if.wind});
`endif
                // Target hit outranks terrain, terrain outranks leaving the screen.
                if (w_hit) begin
                    state_d = S_EXPLODE;
                    x_d     = w_nx[10:0];
                    y_d     = w_ny[10:0];
                    hit_d   = 1'b1;
                    exp_d   = '0;
                    rad_d   = 4'd1;
                end else if (w_ground) begin
                    state_d = S_EXPLODE;
                    x_d     = w_nx[10:0];
                    y_d     = w_ter[10:0];
                    exp_d   = '0;
                    rad_d   = 4'd1;
                end else if (w_off) begin
                    state_d = S_IDLE;
                    miss_d  = 1'b1;
                end else begin
                    x_d = w_nx[10:0];
                    y_d = w_ny[10:0];
                end
            end
            S_EXPLODE: begin
                if (exp_q == C_EXP_LAST) begin
                    state_d = S_IDLE;
                    exp_d   = '0;
                    rad_d   = '0;
                end else begin
                    exp_d = exp_q + 1'b1;
                    if (rad_q < C_RMAX)
                        rad_d = rad_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign shell_if.terrain_x      = w_nx[9:0];
    assign shell_if.ShellX         = x_q[9:0];
    assign shell_if.ShellY         = y_q[10] ? 10'd0 : y_q[9:0];
    assign shell_if.shell_active   = (state_q == S_FLIGHT) && !y_q[10];
    assign shell_if.explode_active = (state_q == S_EXPLODE);
    assign shell_if.ExplodeR       = rad_q;
    assign shell_if.hit            = hit_q;
    assign shell_if.miss           = miss_q;
    assign shell_if.busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tank_shell.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_shell
// Desc     : Self-checking bench for tank_shell: trajectory scoreboard,
//            outcome vector table and hand sequences for reset/explosion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_shell;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tank_shell_if bus();
    tank_shell dut (.frame_clk(clk), .Reset_n(rst_n), .shell_if(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int x; int y; } pos_t;
    pos_t sb_q[$];

    typedef struct {
        int tx, ty, dir, yc, gx, gy, ter;
        int frames, lastx, hit, miss, ox, oy;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int tx, ty, dir, yc, gx, gy, ter);
        bus.shoot       = 1'b0;
        bus.TankX       = 10'(tx);
        bus.TankY       = 10'(ty);
        bus.Direction   = 2'(dir);
        bus.y_component = 10'(yc);
        bus.TargetX     = 10'(gx);
        bus.TargetY     = 10'(gy);
        bus.terrain_y   = 10'(ter);
    endtask

    task automatic fire();
        bus.shoot = 1'b1;
        tick();
        bus.shoot = 1'b0;
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ex[10] = '{500, 498, 496, 494, 492, 490, 488, 486, 484, 482};
        int ey[10] = '{194, 188, 182, 176, 170, 165, 160, 155, 150, 146};
        pos_t p;

        vt[0] = '{100, 200, 1,    0, 600,  50,  210, 14, 126, 0, 0, 128, 210};
        vt[1] = '{  4, 200, 0,    0, 600,  50,  479,  3,   0, 0, 1,  -1,  -1};
        vt[2] = '{636, 200, 3,    0, 600,  50,  479,  2, 638, 0, 1,  -1,  -1};
        vt[3] = '{100, 478, 1,  -20, 600,  50, 1000,  1, 100, 0, 1,  -1,  -1};
        vt[4] = '{300, 300, 1,    0, 302, 294,  290,  1, 300, 1, 0, 302, 294};
        vt[5] = '{100, 200, 1, -100, 102, 209,  300,  1, 100, 1, 0, 102, 209};
        vt[6] = '{100, 200, 1,  100, 102, 179,  479,  1, 100, 1, 0, 102, 179};

        setup(0, 0, 0, 0, 0, 0, 479);
`ifdef TANK_SHELL_WIND_EN
        bus.wind = 3'sd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_active",  32'(bus.shell_active), 0);
        chk("rst_explode", 32'(bus.explode_active), 0);
        chk("rst_x",       32'(bus.ShellX), 0);
        chk("rst_y",       32'(bus.ShellY), 0);
        chk("rst_r",       32'(bus.ExplodeR), 0);
        chk("rst_hit",     32'(bus.hit), 0);
        chk("rst_miss",    32'(bus.miss), 0);
        #2 rst_n = 1'b1;
        tick();

        // Launch trajectory with a mid-flight re-fire that must be ignored
        setup(500, 200, 0, 12, 100, 100, 479);
        for (int i = 0; i < 10; i++) begin
            p.x = ex[i];
            p.y = ey[i];
            sb_q.push_back(p);
        end
        fire();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            if (i == 4) bus.shoot = 1'b0;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                p = sb_q.pop_front();
                chk($sformatf("traj%0d_x", i), 32'(bus.ShellX), p.x);
                chk($sformatf("traj%0d_y", i), 32'(bus.ShellY), p.y);
            end
            chk($sformatf("traj%0d_act", i), 32'(bus.shell_active), 1);
            if (i == 3) bus.shoot = 1'b1;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_act",  32'(bus.shell_active), 0);
        chk("async_x",    32'(bus.ShellX), 0);
        #1 rst_n = 1'b1;
        tick();

        // Target hit and explosion phase
        setup(500, 200, 0, 12, 494, 182, 479);
        fire();
        chk("hit_f0_x", 32'(bus.ShellX), 500);
        tick();
        chk("hit_f1_x", 32'(bus.ShellX), 498);
        chk("hit_f1_expl", 32'(bus.explode_active), 0);
        tick();
        chk("hit_pulse", 32'(bus.hit), 1);
        chk("hit_miss",  32'(bus.miss), 0);
        chk("hit_expl",  32'(bus.explode_active), 1);
        chk("hit_x",     32'(bus.ShellX), 496);
        chk("hit_y",     32'(bus.ShellY), 182);
        chk("hit_r1",    32'(bus.ExplodeR), 1);
        chk("hit_act",   32'(bus.shell_active), 0);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk($sformatf("expl%0d_hit", k), 32'(bus.hit), 0);
            chk($sformatf("expl%0d_act", k), 32'(bus.explode_active), 1);
            chk($sformatf("expl%0d_r", k),   32'(bus.ExplodeR), (k < 8) ? k : 8);
        end
        bus.shoot = 1'b1;
        tick();
        bus.shoot = 1'b0;
        chk("expl_end_busy", 32'(bus.busy), 0);
        chk("expl_end_r",    32'(bus.ExplodeR), 0);
        tick();
        chk("expl_end_noqueue", 32'(bus.busy), 0);

        // Outcome table: terrain, screen exits, priority, aim saturation
        for (int i = 0; i < 7; i++) begin
            pulse_reset();
            tick();
            setup(vt[i].tx, vt[i].ty, vt[i].dir, vt[i].yc, vt[i].gx, vt[i].gy, vt[i].ter);
            fire();
            for (int f = 0; f < vt[i].frames; f++) begin
                if (f > 0) tick();
                chk($sformatf("vec%0d_f%0d_busy", i, f), 32'(bus.busy), 1);
                chk($sformatf("vec%0d_f%0d_expl", i, f), 32'(bus.explode_active), 0);
                if (f == vt[i].frames - 1)
                    chk($sformatf("vec%0d_lastx", i), 32'(bus.ShellX), vt[i].lastx);
            end
            tick();
            chk($sformatf("vec%0d_hit", i),  32'(bus.hit), vt[i].hit);
            chk($sformatf("vec%0d_miss", i), 32'(bus.miss), vt[i].miss);
            chk($sformatf("vec%0d_expl", i), 32'(bus.explode_active), 1 - vt[i].miss);
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 1 - vt[i].miss);
            if (vt[i].miss == 0) begin
                chk($sformatf("vec%0d_x", i), 32'(bus.ShellX), vt[i].ox);
                chk($sformatf("vec%0d_y", i), 32'(bus.ShellY), vt[i].oy);
            end
            tick();
            chk($sformatf("vec%0d_hit_1f", i),  32'(bus.hit), 0);
            chk($sformatf("vec%0d_miss_1f", i), 32'(bus.miss), 0);
            chk($sformatf("vec%0d_expl_mx", i), 32'(bus.explode_active), 1 - vt[i].miss);
        end

        // Shell above the top of the screen
        pulse_reset();
        tick();
        setup(100, 10, 1, 100, 600, 50, 479);
        fire();
        chk("up_f0_y",   32'(bus.ShellY), 4);
        chk("up_f0_act", 32'(bus.shell_active), 1);
        tick();
        chk("up_f1_y",    32'(bus.ShellY), 0);
        chk("up_f1_act",  32'(bus.shell_active), 0);
        chk("up_f1_busy", 32'(bus.busy), 1);
        chk("up_f1_x",    32'(bus.ShellX), 102);

`ifdef TANK_SHELL_WIND_EN
        pulse_reset();
        tick();
        setup(500, 400, 0, 0, 100, 50, 479);
        bus.wind = 3'sd1;
        fire();
        for (int f = 1; f <= 18; f++) begin
            tick();
            if (f == 8)  chk("wind_f8_x",  32'(bus.ShellX), 484);
            if (f == 16) chk("wind_f16_x", 32'(bus.ShellX), 476);
            if (f == 18) chk("wind_f18_x", 32'(bus.ShellX), 476);
        end
        bus.wind = 3'sd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tank_shell.md
Name: tank_shell

Overview:
- Ballistic projectile engine sitting directly downstream of the tank controller.
- Consumes the controller's one-frame `shoot` pulse, tank position, `Direction` and aim `y_component`.
- Flies one shell per frame tick under integer gravity, detects target hit, terrain impact or off-screen exit, then runs an expanding-explosion phase.
- Outputs drive the sprite/colour mapper and scoring logic.

Parameters:
- `VX_SPEED`, 2: horizontal speed, pixels/frame.
- `AIM_SHIFT`, 1: initial vy = -(`y_component` >>> `AIM_SHIFT`).
- `VY_MAX`, 15: vy saturates to [-VY_MAX, +VY_MAX].
- `GRAV_DIV`, 4: vy += 1 once every `GRAV_DIV` flight frames.
- `LAUNCH_OFS`, 6: shell spawns this many pixels above the tank centre.
- `HIT_R`, 4: hit box half-width around the target, pixels.
- `EXPLODE_R_MAX`, 8: maximum explosion radius.
- `EXPLODE_FRAMES`, 16: total frames spent in EXPLODE.

Ports:
- `frame_clk`  in  1  frame tick clock (one edge per video frame).
- `Reset_n`  in  1  asynchronous active-low reset.
- `shoot`  in  1  one-frame fire pulse from the tank controller.
- `TankX`, `TankY`  in  10  firing tank centre.
- `Direction`  in  2  0 = left, 1 = right; 2/3 treated as right.
- `y_component`  in  10  signed two's-complement aim value.
- `TargetX`, `TargetY`  in  10  opposing tank centre.
- `terrain_x`  out  10  column being probed: low 10 bits of next x (combinational).
- `terrain_y`  in  10  ground height at `terrain_x` (combinational return, same cycle).
- `ShellX`, `ShellY`  out  10  shell position; `ShellY` clamped to 0 while above the screen.
- `shell_active`  out  1  state == FLIGHT and y >= 0.
- `explode_active`  out  1  state == EXPLODE.
- `ExplodeR`  out  4  explosion radius.
- `hit`  out  1  one-frame pulse on target hit.
- `miss`  out  1  one-frame pulse on off-screen exit.
- `busy`  out  1  state != IDLE.

Behaviour:
- Internal state: x, y signed 11-bit; vx, vy signed 6-bit; gravity counter; explode frame counter.
- States: IDLE, FLIGHT, EXPLODE. All transitions on rising `frame_clk`.
- Reset (`Reset_n` = 0, asynchronous, effective at any time including mid-flight):
  - State goes to IDLE.
  - All outputs 0; x, y, vx, vy, counters cleared.
- IDLE:
  - `shoot` = 1 → FLIGHT next edge.
  - Latch x = `TankX`, y = `TankY` - `LAUNCH_OFS`.
  - vx = -`VX_SPEED` if `Direction` == 0, else +`VX_SPEED`.
  - vy = sat(-(`y_component` >>> `AIM_SHIFT`)).
  - Gravity counter cleared.
  - Latency: shoot sampled at edge N → shell visible at its launch point after edge N.
- FLIGHT, each edge:
  - Compute nx = x + vx, ny = y + vy using the old vy.
  - Gravity counter increments; on reaching `GRAV_DIV`-1 it clears and vy = sat(vy + 1) in the same edge.
  - Exit checks use nx/ny in strict priority:
    1. |nx - `TargetX`| <= `HIT_R` and |ny - `TargetY`| <= `HIT_R` → EXPLODE, latch x = nx, y = ny, `hit` = 1 for one frame.
    2. ny >= 0 and ny >= `terrain_y` → EXPLODE, latch x = nx, y = `terrain_y`.
    3. nx < 0, nx > 639, or ny > 479 → IDLE, `miss` = 1 for one frame.
    4. Otherwise stay in FLIGHT with x = nx, y = ny.
  - ny < 0 is legal flight: `shell_active` = 0, `ShellY` output = 0.
- EXPLODE:
  - `ExplodeR` = 1 on entry, then +1 per frame, saturating at `EXPLODE_R_MAX`.
  - After `EXPLODE_FRAMES` frames → IDLE; `ExplodeR` cleared.
- `shoot` is ignored in FLIGHT and EXPLODE; no queuing.
- `shoot` arriving on the same edge as a return to IDLE is also ignored.
- `hit` and `miss` are never asserted together.

Optional Feature:
- Macro: `TANK_SHELL_WIND_EN`.
- Defined:
  - Adds input `wind` (signed 3-bit).
  - Every 8 flight frames, vx = sat(vx + `wind`) to ±`VY_MAX`.
  - vx is reset to the `Direction`-based value at each launch.
- Undefined: no `wind` port; vx is constant throughout flight.

Test Plan:
- Launch:
  - Setup: `TankX` = 500, `TankY` = 200, `Direction` = 0, `y_component` = 12, `terrain_y` = 479, target far away; pulse `shoot`.
  - Expected: `ShellX`/`ShellY` = 500/194, then 498/188, 496/182, 494/176, 492/170; vy = -5 after 4 flight frames.
- Target hit:
  - Setup: as the launch test, with `TargetX`/`TargetY` = 494/182.
  - Expected: second flight edge enters EXPLODE at 496/182; `hit` high exactly one frame; `ExplodeR` steps 1..8 then holds; IDLE after 16 frames.
- Terrain impact:
  - Setup: `Direction` = 1, `y_component` = 0, `terrain_y` = 210, `TankX`/`TankY` = 100/200.
  - Expected: EXPLODE with `ShellY` = 210; `hit` = 0, `miss` = 0.
- Edge exit:
  - Setup: `TankX` = 4, `Direction` = 0, `y_component` = 0.
  - Expected: x goes 4 → 2 → 0; the third flight edge yields IDLE, `miss` = 1 for one frame, `explode_active` never 1.
- Busy and reset:
  - Stimulus: pulse `shoot` again mid-flight.
  - Expected: trajectory unchanged.
  - Stimulus: assert `Reset_n` low mid-flight, between clock edges.
  - Expected: `busy`, `shell_active` and `ShellX` go to 0 immediately, without waiting for a clock edge.
- Wind (`TANK_SHELL_WIND_EN`):
  - Setup: `wind` = +1, `Direction` = 0.
  - Expected: vx goes -2 → -1 after 8 flight frames, → 0 after 16.
